bram_loader_b: RTL and testbench

- Upstream stage of the B-operand scatter.
- Accepts the B matrix as a 32-bit valid/ready stream from the DMA/host side, packs the beats into BRAM_W-bit words, and writes them row-major into the B BRAM (port A) from address 0.
- The scatter reads that BRAM through port B.
- Signals completion with a one-cycle fill_done pulse, which the controller uses to start the scatter; also flags framing (tlast) errors.

---
 rtl/bram_loader_b.sv | 142 ++++++++++++++
 tb/tb_bram_loader_b.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_loader_b.sv
// B-operand BRAM loader: packs a 32-bit valid/ready stream into wide words
// and writes them row-major into BRAM port A starting at address 0.
module bram_loader_b #(
    parameter int W             = 8,
    parameter int S_W           = 32,
    parameter int BRAM_W        = 128,
    parameter int BRAM_AW       = 10,
    parameter int DATA_B_SIZE_X = 64,
    parameter int DATA_B_SIZE_Y = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [S_W-1:0]     s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               s_tlast,
    output logic               bram_clk_a,
    output logic               bram_en_a,
    output logic               bram_we_a,
    output logic [BRAM_AW-1:0] bram_addr_a,
    output logic [BRAM_W-1:0]  bram_wrdata_a,
    output logic               busy,
    output logic               fill_done,
    output logic               err_tlast,
    output logic [BRAM_AW:0]   word_cnt
);

    localparam int K      = BRAM_W / S_W;
    localparam int NWORDS = DATA_B_SIZE_X * DATA_B_SIZE_Y * W / BRAM_W;
    localparam int NBEATS = NWORDS * K;
    localparam int BCW    = $clog2(NBEATS) + 1;
    localparam int LW     = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        DONE
    } state_t;

    state_t          state;
    logic [LW-1:0]   lane;
    logic [BCW-1:0]  beat_cnt;
    logic [BRAM_W-1:0] pack;
    logic [BRAM_W-1:0] pack_nxt;
    logic            accept;
    logic            last_lane;
    logic            last_beat;

    assign bram_clk_a = clk;
    assign bram_en_a  = bram_we_a;
    assign s_tready   = (state == FILL);
    assign accept     = s_tvalid & s_tready;
    assign last_lane  = (lane == LW'(K - 1));
    assign last_beat  = (beat_cnt == BCW'(NBEATS - 1));

    always_comb begin
        pack_nxt = pack;
        pack_nxt[lane*S_W +: S_W] = s_tdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lane          <= '0;
            beat_cnt      <= '0;
            pack          <= '0;
            bram_we_a     <= 1'b0;
            bram_addr_a   <= '0;
            bram_wrdata_a <= '0;
            busy          <= 1'b0;
            fill_done     <= 1'b0;
            err_tlast     <= 1'b0;
            word_cnt      <= '0;
        end else begin
            bram_we_a <= 1'b0;
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FILL;
                        busy        <= 1'b1;
                        bram_addr_a <= '0;
                        lane        <= '0;
                        beat_cnt    <= '0;
                        word_cnt    <= '0;
                        err_tlast   <= 1'b0;
                        pack        <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // Pack is cleared after each write so a flushed
                        // partial word carries zeros in its unfilled slices.
                        if (last_lane) begin
                            bram_wrdata_a <= pack_nxt;
                            bram_we_a     <= 1'b1;
                            bram_addr_a   <= word_cnt[BRAM_AW-1:0];
                            word_cnt      <= word_cnt + 1'b1;
                            pack          <= '0;
                            lane          <= '0;
                        end else begin
                            pack <= pack_nxt;
                            lane <= lane + 1'b1;
                        end
                        if (last_beat) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            err_tlast <= err_tlast | ~s_tlast;
                        end else if (s_tlast) begin
                            err_tlast <= 1'b1;
                            if (last_lane) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end else begin
                                state <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    bram_wrdata_a <= pack;
                    bram_we_a     <= 1'b1;
                    bram_addr_a   <= word_cnt[BRAM_AW-1:0];
                    word_cnt      <= word_cnt + 1'b1;
                    pack          <= '0;
                    lane          <= '0;
                    state         <= DONE;
                    busy          <= 1'b0;
                end
                DONE: begin
                    fill_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_loader_b.sv
// Directed bench for bram_loader_b: full, throttled, early/missing tlast,
// start during fill and asynchronous reset mid-fill.
module tb_bram_loader_b;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic         bram_clk_a;
    logic         bram_en_a;
    logic         bram_we_a;
    logic [9:0]   bram_addr_a;
    logic [127:0] bram_wrdata_a;
    logic         busy;
    logic         fill_done;
    logic         err_tlast;
    logic [10:0]  word_cnt;

    bram_loader_b dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tlast       (s_tlast),
        .bram_clk_a    (bram_clk_a),
        .bram_en_a     (bram_en_a),
        .bram_we_a     (bram_we_a),
        .bram_addr_a   (bram_addr_a),
        .bram_wrdata_a (bram_wrdata_a),
        .busy          (busy),
        .fill_done     (fill_done),
        .err_tlast     (err_tlast),
        .word_cnt      (word_cnt)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge.
    logic [127:0] mem [1024];
    int           mem_tag [1024];
    int           addr_log [8192];
    int           test_id = 0;
    int           we_cnt = 0;
    int           done_cnt = 0;
    int           en_bad = 0;
    int           cyc_n = 0;
    int           last_we_cyc = 0;
    int           done_cyc = 0;

    always @(negedge clk) begin
        cyc_n++;
        if (bram_we_a) begin
            mem[bram_addr_a] = bram_wrdata_a;
            mem_tag[bram_addr_a] = test_id;
            if (we_cnt < 8192) addr_log[we_cnt] = int'(bram_addr_a);
            we_cnt++;
            last_we_cyc = cyc_n;
        end
        if (bram_en_a !== bram_we_a) en_bad++;
        if (fill_done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
    end

    int passed = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] exp_word(input int w);
        return {32'(4*w+3), 32'(4*w+2), 32'(4*w+1), 32'(4*w)};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams beats 0..n-1 with s_tdata = beat index; returns beats accepted.
    task automatic stream(input int n, input int last_at, input int duty,
                          input int start_at, output int acc_n);
        int i = 0;
        int cyc = 0;
        bit v;
        bit acc;
        while (i < n && cyc < 20000) begin
            v = (duty >= 100) || ($urandom_range(0, 99) < duty);
            s_tvalid = v;
            s_tdata  = 32'(i);
            s_tlast  = (i == last_at);
            start    = v && (i == start_at);
            acc      = v && s_tready;
            @(posedge clk);
            @(negedge clk);
            if (acc) i++;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        start    = 1'b0;
        acc_n    = i;
    endtask

    task automatic wait_done(input int d0, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (done_cnt > d0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_words(input string tag, input int nw);
        int bad = 0;
        for (int w = 0; w < nw; w++)
            if (mem[w] !== exp_word(w) || mem_tag[w] != test_id) bad++;
        chk(tag, 128'(bad), 128'd0);
    endtask

    task automatic full_run(input string tag, input int last_at,
                            input int duty, input int start_at,
                            input logic exp_err);
        int  w0;
        int  d0;
        int  acc_n;
        bit  seen;
        test_id++;
        w0 = we_cnt;
        d0 = done_cnt;
        pulse_start();
        chk({tag, " busy"}, 128'(busy), 128'd1);
        stream(1024, last_at, duty, start_at, acc_n);
        chk({tag, " beats"}, 128'(acc_n), 128'd1024);
        wait_done(d0, seen);
        chk({tag, " done seen"}, 128'(seen), 128'd1);
        @(negedge clk);
        chk({tag, " writes"}, 128'(we_cnt - w0), 128'd256);
        chk({tag, " first addr"}, 128'(addr_log[w0]), 128'd0);
        check_words({tag, " words"}, 256);
        chk({tag, " word1"}, mem[1], {32'd7, 32'd6, 32'd5, 32'd4});
        chk({tag, " done lat"}, 128'(done_cyc - last_we_cyc), 128'd1);
        chk({tag, " done cnt"}, 128'(done_cnt - d0), 128'd1);
        chk({tag, " word_cnt"}, 128'(word_cnt), 128'd256);
        chk({tag, " err"}, 128'(err_tlast), 128'(exp_err));
        chk({tag, " idle"}, {126'd0, busy, s_tready}, 128'd0);
    endtask

    initial begin
        int  w0;
        int  d0;
        int  acc_n;
        bit  seen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst s_tready", 128'(s_tready), 128'd0);
        chk("rst we/en", {126'd0, bram_we_a, bram_en_a}, 128'd0);
        chk("rst flags", {125'd0, busy, fill_done, err_tlast}, 128'd0);
        chk("rst addr", 128'(bram_addr_a), 128'd0);
        chk("rst wdata", bram_wrdata_a, 128'd0);
        chk("rst word_cnt", 128'(word_cnt), 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Stream beats offered while idle must not be taken.
        s_tvalid = 1'b1;
        @(negedge clk);
        chk("idle no ready", 128'(s_tready), 128'd0);
        s_tvalid = 1'b0;

        full_run("full", 1023, 100, -1, 1'b0);
        full_run("throttled", 1023, 30, -1, 1'b0);

        // Early tlast on beat 9: lane 1 of word 2.
        test_id++;
        w0 = we_cnt;
        d0 = done_cnt;
        pulse_start();
        stream(10, 9, 100, -1, acc_n);
        chk("early beats", 128'(acc_n), 128'd10);
        chk("early ready low", 128'(s_tready), 128'd0);
        wait_done(d0, seen);
        chk("early done seen", 128'(seen), 128'd1);
        @(negedge clk);
        chk("early writes", 128'(we_cnt - w0), 128'd3);
        check_words("early words", 2);
        chk("early word2", mem[2], {64'h0, 32'd9, 32'd8});
        chk("early word_cnt", 128'(word_cnt), 128'd3);
        chk("early err", 128'(err_tlast), 128'd1);

        full_run("no tlast", -1, 100, -1, 1'b1);
        full_run("start mid", 1023, 100, 500, 1'b0);

        // Asynchronous reset after beat 130, between clock edges.
        test_id++;
        pulse_start();
        stream(131, -1, 100, -1, acc_n);
        chk("arst beats", 128'(acc_n), 128'd131);
        chk("arst ready before", 128'(s_tready), 128'd1);
        w0 = we_cnt;
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("arst ready drop", 128'(s_tready), 128'd0);
        chk("arst we drop", {126'd0, bram_we_a, bram_en_a}, 128'd0);
        chk("arst busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("arst no writes", 128'(we_cnt - w0), 128'd0);
        chk("arst no done", 128'(done_cnt - d0), 128'd0);
        chk("arst word_cnt", 128'(word_cnt), 128'd0);

        full_run("restart", 1023, 100, -1, 1'b0);

        chk("en equals we", 128'(en_bad), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
